// File: rtl/keynsham_fetch_buffer_pkg.sv
// Shared definitions for the Keynsham fetch front end: FSM encoding and
// the layout of one FIFO entry ({fault, instr, word pc}).
package keynsham_fetch_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2,
    ST_FAULTED = 2'd3
  } fetch_state_e;

  localparam int ENTRY_W   = 63;
  localparam int FAULT_BIT = 62;
  localparam int INSTR_MSB = 61;
  localparam int INSTR_LSB = 30;
  localparam int PC_MSB    = 29;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic fault,
                                                    input logic [31:0] instr,
                                                    input logic [29:0] pc);
    return {fault, instr, pc};
  endfunction

endpackage

// File: rtl/keynsham_fetch_buffer_if.sv
// Instruction bus plus decode-side handshake of the fetch buffer.
interface keynsham_fetch_buffer_if;
  logic        i_access;
  logic [29:0] i_addr;
  logic [31:0] i_data;
  logic        i_ack;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  modport master (
    output i_access, i_addr, out_valid, out_instr, out_pc, out_fault,
    input  i_data, i_ack, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  i_access, i_addr, out_valid, out_instr, out_pc, out_fault,
    output i_data, i_ack, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/keynsham_fetch_buffer_fifo.sv
// Synchronous FIFO with a registered head word that holds its last value
// when the FIFO drains, plus a flush that empties it in one edge.
module keynsham_fetch_fifo
  import keynsham_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r, wr_ptr_n, rd_ptr_n;
  logic [PW:0]      count_r, count_n;
  logic [WIDTH-1:0] head_r, head_n;
  logic             full_r, empty_r, do_push_s, do_pop_s;

  // Next pointers/occupancy; the new head bypasses the array when it is the word being written.
  always_comb begin
    do_pop_s  = pop && (count_r != {(PW+1){1'b0}});
    do_push_s = push && ((count_r != (PW+1)'(DEPTH)) || do_pop_s);
    wr_ptr_n  = wr_ptr_r;
    rd_ptr_n  = rd_ptr_r;
    count_n   = count_r;
    head_n    = head_r;
    if (flush) begin
      wr_ptr_n = {PW{1'b0}};
      rd_ptr_n = {PW{1'b0}};
      count_n  = {(PW+1){1'b0}};
    end else begin
      wr_ptr_n = wr_ptr_r + PW'(do_push_s);
      rd_ptr_n = rd_ptr_r + PW'(do_pop_s);
      count_n  = count_r + (PW+1)'(do_push_s) - (PW+1)'(do_pop_s);
      if (count_n != {(PW+1){1'b0}}) begin
        head_n = (do_push_s && (wr_ptr_r == rd_ptr_n)) ? push_data : mem_r[rd_ptr_n];
      end else begin
        head_n = head_r;
      end
    end
  end

  // Storage array, no reset needed since the head register masks stale words.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Control and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
      head_r   <= {WIDTH{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_n;
      rd_ptr_r <= rd_ptr_n;
      count_r  <= count_n;
      head_r   <= head_n;
      full_r   <= (count_n == (PW+1)'(DEPTH));
      empty_r  <= (count_n == {(PW+1){1'b0}});
    end
  end

  assign head  = head_r;
  assign full  = full_r;
  assign empty = empty_r;
  assign count = count_r;
endmodule

// File: rtl/keynsham_fetch_buffer.sv
// Instruction-fetch front end: issues sequential word fetches, buffers them
// in a small FIFO and handles redirects and bus-timeout faults.
module keynsham_fetch_buffer
  import keynsham_fetch_buffer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1000_0000,
  parameter int          DEPTH    = 4,
  parameter int          TIMEOUT  = 15
) (
  input logic clk,
  input logic rst_n,
  keynsham_fetch_buffer_if.master bus
);
  localparam int             CW        = $clog2(DEPTH) + 1;
  localparam logic [7:0]     TIMEOUT_C = 8'(TIMEOUT);

  fetch_state_e       state_r, state_n;
  logic [29:0]        addr_r, addr_n, pend_r, pend_n;
  logic [7:0]         cnt_r, cnt_n, cnt_inc_s;
  logic               timed_out_s, credit_s, push_s, push_fault_s, pop_s, i_access_r;
  logic [ENTRY_W-1:0] push_entry_s, head_s;
  logic               fifo_full_s, fifo_empty_s;
  logic [CW-1:0]      fifo_count_s;

  assign credit_s = ({1'b0, fifo_count_s} + {{CW{1'b0}}, (state_r == ST_REQ)}) < (CW+1)'(DEPTH);
  assign pop_s    = !fifo_empty_s && bus.out_ready && !bus.redirect;
  assign push_entry_s = push_fault_s ? make_entry(1'b1, 32'd0, addr_r)
                                     : make_entry(1'b0, bus.i_data, addr_r);

  // Fetch FSM: redirect wins over everything, the timeout counter saturates at TIMEOUT.
  always_comb begin
    state_n      = state_r;
    addr_n       = addr_r;
    pend_n       = pend_r;
    cnt_n        = cnt_r;
    push_s       = 1'b0;
    push_fault_s = 1'b0;
    cnt_inc_s    = (cnt_r == TIMEOUT_C) ? cnt_r : cnt_r + 8'd1;
    timed_out_s  = (cnt_inc_s == TIMEOUT_C);
    case (state_r)
      ST_IDLE: begin
        if (bus.redirect) begin
          addr_n = bus.redirect_pc[31:2];
        end else if (credit_s) begin
          state_n = ST_REQ;
          cnt_n   = 8'd0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.redirect) begin
          if (bus.i_ack) begin
            state_n = ST_IDLE;
            addr_n  = bus.redirect_pc[31:2];
          end else begin
            state_n = ST_DISCARD;
            pend_n  = bus.redirect_pc[31:2];
            cnt_n   = 8'd0;
          end
        end else if (bus.i_ack) begin
          push_s  = 1'b1;
          addr_n  = addr_r + 30'd1;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt_inc_s;
          if (timed_out_s && (!fifo_full_s || pop_s)) begin
            push_s       = 1'b1;
            push_fault_s = 1'b1;
            state_n      = ST_FAULTED;
          end else begin
            state_n = ST_REQ;
          end
        end
      end
      ST_DISCARD: begin
        // The in-flight fetch still owns the bus; only the pending target moves.
        if (bus.i_ack || timed_out_s) begin
          state_n = ST_IDLE;
          addr_n  = bus.redirect ? bus.redirect_pc[31:2] : pend_r;
        end else begin
          cnt_n  = cnt_inc_s;
          pend_n = bus.redirect ? bus.redirect_pc[31:2] : pend_r;
        end
      end
      ST_FAULTED: begin
        if (bus.redirect) begin
          state_n = ST_IDLE;
          addr_n  = bus.redirect_pc[31:2];
        end else begin
          state_n = ST_FAULTED;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, address and bus request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      addr_r     <= RESET_PC[31:2];
      pend_r     <= RESET_PC[31:2];
      cnt_r      <= 8'd0;
      i_access_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      addr_r     <= addr_n;
      pend_r     <= pend_n;
      cnt_r      <= cnt_n;
      i_access_r <= (state_n == ST_REQ) || (state_n == ST_DISCARD);
    end
  end

  keynsham_fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.redirect),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign bus.i_access  = i_access_r;
  assign bus.i_addr    = addr_r;
  assign bus.out_valid = !fifo_empty_s;
  assign bus.out_fault = head_s[FAULT_BIT];
  assign bus.out_instr = head_s[INSTR_MSB:INSTR_LSB];
  assign bus.out_pc    = {head_s[PC_MSB:0], 2'b00};
endmodule

// File: tb/tb_keynsham_fetch_buffer.sv
// Self-checking bench for keynsham_fetch_buffer: directed scenarios plus a
// randomized run against a queue-based model of the fetched instruction stream.
module tb_keynsham_fetch_buffer;
  localparam logic [31:0] RESET_PC = 32'h1000_0000;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  int slave_lat = 0;
  int slave_cnt = 0;
  bit slave_en = 1'b1;

  keynsham_fetch_buffer_if bus();

  keynsham_fetch_buffer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rom(input logic [31:0] pc);
    return pc ^ 32'hC3A5_5A3C;
  endfunction

  // Waits for a falling edge, then drives decode/redirect inputs and the ROM slave.
  task automatic drive_cycle(input bit rdy, input bit redir, input logic [31:0] rpc);
    @(negedge clk);
    bus.out_ready   = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    if (bus.i_access && slave_en) begin
      bus.i_ack  = (slave_cnt >= slave_lat);
      bus.i_data = bus.i_ack ? rom({bus.i_addr, 2'b00}) : 32'h0;
      slave_cnt++;
    end else begin
      bus.i_ack  = 1'b0;
      bus.i_data = 32'h0;
      slave_cnt  = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_ack = 1'b0; bus.i_data = 32'h0; bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0; bus.out_ready = 1'b0;
    slave_cnt = 0; slave_en = 1'b1; slave_lat = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_ack = 1'b0; bus.i_data = 32'h0; bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.i_access !== 1'b0) begin bad++; $display("FAIL rst_access: got %b want 0", bus.i_access); end
    total++; if (bus.i_addr !== 30'h0400_0000) begin bad++; $display("FAIL rst_addr: got %h want 04000000", bus.i_addr); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    total++; if ({bus.out_instr, bus.out_pc, bus.out_fault} !== 65'd0) begin bad++;
      $display("FAIL rst_head: got %h %h %b want zeros", bus.out_instr, bus.out_pc, bus.out_fault); end
    rst_n = 1'b1;
    slave_en = 1'b1; slave_lat = 0; slave_cnt = 0;
    drive_cycle(1'b1, 1'b0, 32'h0);
    total++; if (bus.i_access !== 1'b1) begin bad++; $display("FAIL first_access: got %b want 1", bus.i_access); end
    total++; if (bus.i_addr !== 30'h0400_0000) begin bad++; $display("FAIL first_addr: got %h want 04000000", bus.i_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc = RESET_PC;
    int npop = 0;
    for (int k = 1; k <= 12; k++) begin
      drive_cycle(1'b1, 1'b0, 32'h0);
      total++; if (bus.i_access !== ((k % 2) == 0)) begin bad++;
        $display("FAIL seq_access k=%0d: got %b want %b", k, bus.i_access, (k % 2) == 0); end
      if (bus.out_valid) begin
        total++; if (bus.out_pc !== exp_pc || bus.out_instr !== rom(exp_pc)) begin bad++;
          $display("FAIL seq_data: got pc %h instr %h want %h %h", bus.out_pc, bus.out_instr, exp_pc, rom(exp_pc)); end
        exp_pc += 32'd4;
        npop++;
      end
    end
    total++; if (npop != 6) begin bad++; $display("FAIL seq_pops: got %0d want 6", npop); end
  endtask

  task automatic test_backpressure();
    int acks = 0;
    do_reset();
    repeat (20) begin
      drive_cycle(1'b0, 1'b0, 32'h0);
      if (bus.i_access && bus.i_ack) acks++;
    end
    total++; if (acks != DEPTH) begin bad++; $display("FAIL bp_acks: got %0d want %0d", acks, DEPTH); end
    total++; if (bus.i_access !== 1'b0 || bus.out_valid !== 1'b1) begin bad++;
      $display("FAIL bp_stall: got access %b valid %b want 0 1", bus.i_access, bus.out_valid); end
    total++; if (bus.out_pc !== RESET_PC) begin bad++; $display("FAIL bp_head: got %h want %h", bus.out_pc, RESET_PC); end
    acks = 0;
    for (int i = 0; i < 11; i++) begin
      drive_cycle(i == 0, 1'b0, 32'h0);
      if (bus.i_access && bus.i_ack) acks++;
    end
    total++; if (acks != 1) begin bad++; $display("FAIL bp_one_more: got %0d want 1", acks); end
    total++; if (bus.i_access !== 1'b0 || bus.out_pc !== RESET_PC + 32'd4) begin bad++;
      $display("FAIL bp_after_pop: got access %b pc %h want 0 %h", bus.i_access, bus.out_pc, RESET_PC + 32'd4); end
  endtask

  task automatic test_redirect_req();
    bit found = 1'b0;
    do_reset();
    slave_lat = 3;
    drive_cycle(1'b0, 1'b1, 32'h1000_0040);
    for (int k = 1; k <= 3; k++) begin
      drive_cycle(1'b0, 1'b0, 32'h0);
      total++; if (bus.i_access !== 1'b1 || bus.i_addr !== 30'h0400_0000) begin bad++;
        $display("FAIL discard_hold k=%0d: got access %b addr %h want 1 04000000", k, bus.i_access, bus.i_addr); end
    end
    total++; if (bus.i_ack !== 1'b1) begin bad++; $display("FAIL discard_ack: got %b want 1", bus.i_ack); end
    slave_lat = 0;
    drive_cycle(1'b1, 1'b0, 32'h0);
    total++; if (bus.i_access !== 1'b0 || bus.i_addr !== 30'h0400_0010 || bus.out_valid !== 1'b0) begin bad++;
      $display("FAIL discard_exit: got access %b addr %h valid %b want 0 04000010 0", bus.i_access, bus.i_addr, bus.out_valid); end
    for (int k = 0; k < 10 && !found; k++) begin
      drive_cycle(1'b1, 1'b0, 32'h0);
      if (bus.out_valid) begin
        found = 1'b1;
        total++; if (bus.out_pc !== 32'h1000_0040 || bus.out_instr !== rom(32'h1000_0040)) begin bad++;
          $display("FAIL redirect_first: got pc %h instr %h want 10000040 %h", bus.out_pc, bus.out_instr, rom(32'h1000_0040)); end
      end
    end
    if (!found) begin total++; bad++; $display("FAIL redirect_first: got no entry want one within 10 cycles"); end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    drive_cycle(1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL ra_pre_valid: got %b want 1", bus.out_valid); end
    drive_cycle(1'b1, 1'b1, 32'h2000_0101);
    total++; if (bus.i_access !== 1'b1 || bus.i_ack !== 1'b1) begin bad++;
      $display("FAIL ra_coincide: got access %b ack %b want 1 1", bus.i_access, bus.i_ack); end
    drive_cycle(1'b0, 1'b0, 32'h0);
    total++; if (bus.out_valid !== 1'b0 || bus.i_access !== 1'b0 || bus.i_addr !== 30'h0800_0040) begin bad++;
      $display("FAIL ra_flush: got valid %b access %b addr %h want 0 0 08000040", bus.out_valid, bus.i_access, bus.i_addr); end
    drive_cycle(1'b1, 1'b0, 32'h0);
    total++; if (bus.i_access !== 1'b1 || bus.i_addr !== 30'h0800_0040) begin bad++;
      $display("FAIL ra_refetch: got access %b addr %h want 1 08000040", bus.i_access, bus.i_addr); end
    drive_cycle(1'b1, 1'b0, 32'h0);
    total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h2000_0100 || bus.out_instr !== rom(32'h2000_0100)) begin bad++;
      $display("FAIL ra_entry: got valid %b pc %h instr %h want 1 20000100 %h", bus.out_valid, bus.out_pc, bus.out_instr, rom(32'h2000_0100)); end
  endtask

  task automatic test_timeout();
    int hi = 0;
    bit found = 1'b0;
    do_reset();
    slave_en = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      drive_cycle(1'b1, 1'b0, 32'h0);
      if (bus.out_valid) found = 1'b1;
      else if (bus.i_access) hi++;
    end
    total++; if (!found || hi != TIMEOUT) begin bad++; $display("FAIL to_cycles: got found %b high %0d want 1 %0d", found, hi, TIMEOUT); end
    total++; if (bus.out_fault !== 1'b1 || bus.out_instr !== 32'h0 || bus.out_pc !== RESET_PC) begin bad++;
      $display("FAIL to_entry: got fault %b instr %h pc %h want 1 0 %h", bus.out_fault, bus.out_instr, bus.out_pc, RESET_PC); end
    hi = 0;
    repeat (20) begin
      drive_cycle(1'b1, 1'b0, 32'h0);
      if (bus.i_access) hi++;
    end
    total++; if (hi != 0 || bus.out_valid !== 1'b0) begin bad++;
      $display("FAIL to_parked: got access cycles %0d valid %b want 0 0", hi, bus.out_valid); end
    slave_en = 1'b1; slave_lat = 1;
    drive_cycle(1'b1, 1'b1, 32'h0000_0080);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      drive_cycle(1'b1, 1'b0, 32'h0);
      if (bus.out_valid) begin
        found = 1'b1;
        total++; if (bus.out_pc !== 32'h80 || bus.out_fault !== 1'b0 || bus.out_instr !== rom(32'h80)) begin bad++;
          $display("FAIL to_restart: got pc %h fault %b instr %h want 80 0 %h", bus.out_pc, bus.out_fault, bus.out_instr, rom(32'h80)); end
      end
    end
    if (!found) begin total++; bad++; $display("FAIL to_restart: got no entry want one within 10 cycles"); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_cycle(1'b0, 1'b0, 32'h0);
    slave_en = 1'b0;
    drive_cycle(1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0);
    total++; if (bus.i_access !== 1'b1 || bus.out_valid !== 1'b1) begin bad++;
      $display("FAIL ar_pre: got access %b valid %b want 1 1", bus.i_access, bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.i_access !== 1'b0 || bus.out_valid !== 1'b0 || bus.i_addr !== 30'h0400_0000) begin bad++;
      $display("FAIL ar_async: got access %b valid %b addr %h want 0 0 04000000", bus.i_access, bus.out_valid, bus.i_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    slave_en = 1'b1;
    drive_cycle(1'b0, 1'b0, 32'h0);
    total++; if (bus.i_access !== 1'b1 || bus.i_addr !== 30'h0400_0000) begin bad++;
      $display("FAIL ar_restart: got access %b addr %h want 1 04000000", bus.i_access, bus.i_addr); end
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr = RESET_PC;
    logic [31:0] old_addr = RESET_PC;
    logic [31:0] rpc;
    bit discard = 1'b0;
    bit rdy, redir;
    int npop = 0;
    do_reset();
    slave_lat = 1;
    for (int n = 0; n < 600; n++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 19) == 0);
      rpc   = 32'h1000_0000 + 32'($urandom_range(0, 255));
      drive_cycle(rdy, redir, rpc);
      total++; if (bus.out_valid !== (exp_q.size() != 0)) begin bad++;
        $display("FAIL rnd_valid n=%0d: got %b want %b", n, bus.out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        total++; if (bus.out_pc !== exp_q[0] || bus.out_instr !== rom(exp_q[0]) || bus.out_fault !== 1'b0) begin bad++;
          $display("FAIL rnd_head n=%0d: got pc %h instr %h fault %b want %h %h 0", n, bus.out_pc, bus.out_instr, bus.out_fault, exp_q[0], rom(exp_q[0])); end
      end
      if (discard) begin
        total++; if (bus.i_access !== 1'b1 || bus.i_addr !== old_addr[31:2]) begin bad++;
          $display("FAIL rnd_discard n=%0d: got access %b addr %h want 1 %h", n, bus.i_access, bus.i_addr, old_addr[31:2]); end
      end else if (bus.i_access) begin
        total++; if (bus.i_addr !== exp_addr[31:2]) begin bad++;
          $display("FAIL rnd_addr n=%0d: got %h want %h", n, bus.i_addr, exp_addr[31:2]); end
      end
      if (redir) begin
        exp_q.delete();
        if (bus.i_access && !bus.i_ack) begin
          if (!discard) old_addr = exp_addr;
          discard = 1'b1;
        end else begin
          discard = 1'b0;
        end
        exp_addr = rpc & 32'hFFFF_FFFC;
      end else begin
        if (exp_q.size() != 0 && rdy) begin
          void'(exp_q.pop_front());
          npop++;
        end
        if (bus.i_access && bus.i_ack) begin
          if (discard) discard = 1'b0;
          else begin
            exp_q.push_back(exp_addr);
            exp_addr += 32'd4;
          end
        end
      end
      if (bus.i_ack) slave_lat = $urandom_range(0, 3);
      total++; if (exp_q.size() > DEPTH) begin bad++; $display("FAIL rnd_overfill n=%0d: got %0d want <= %0d", n, exp_q.size(), DEPTH); end
    end
    total++; if (npop < 50) begin bad++; $display("FAIL rnd_progress: got %0d pops want >= 50", npop); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_req();
    test_redirect_ack();
    test_timeout();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
